// File: rtl/enemy_pool_if.sv
`default_nettype none
// ============================================================================
// Module      : enemy_pool_if
// Description : Spawner / renderer bundle for enemy_pool. The spawner drives
//               the requests and reads the enemy state.
// Revision    : 1.0 - initial release
// ============================================================================
interface enemy_pool_if;
    logic        spawn;
    logic [3:0]  random_number;
    logic        move_tick;
    logic        kill;
    logic [2:0]  kill_slot;
    logic [3:0]  enemy_count;
    logic [7:0]  active_mask;
    logic [79:0] pos_x;
    logic [79:0] pos_y;
    logic [7:0]  escaped;
    logic        spawned_pulse;

    modport master (
        output spawn, random_number, move_tick, kill, kill_slot,
        input  enemy_count, active_mask, pos_x, pos_y, escaped, spawned_pulse
    );

    modport slave (
        input  spawn, random_number, move_tick, kill, kill_slot,
        output enemy_count, active_mask, pos_x, pos_y, escaped, spawned_pulse
    );
endinterface
`default_nettype wire

// File: rtl/enemy_pool.sv
`default_nettype none
// ============================================================================
// Module      : enemy_pool
// Description : Eight-slot enemy pool with spawn holdoff, per-frame movement,
//               kill and escape tracking. Define ENEMY_ZIGZAG_EN for X drift.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_pool #(
    parameter int SCREEN_H = 480,
    parameter int X_STEP   = 36,
    parameter int SPEED    = 2,
    parameter int HOLDOFF  = 1000
`ifdef ENEMY_ZIGZAG_EN
    ,
    parameter int DRIFT    = 1,
    parameter int SCREEN_W = 640,
    parameter int ENEMY_W  = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    enemy_pool_if.slave bus
);

    localparam int c_NSLOT = 8;
    localparam int c_HW    = $clog2(HOLDOFF + 1);

    function automatic logic [3:0] f_popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < c_NSLOT; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    logic [c_HW-1:0] r_holdoff;
    logic [3:0]      r_count;
    logic [7:0]      r_escaped;
    logic            r_spawned;

    logic [7:0]      w_active;
    logic [7:0]      w_escape;
    logic [79:0]     w_pos_x;
    logic [79:0]     w_pos_y;
    logic [2:0]      w_free_idx;
    logic            w_accept;
    logic [9:0]      w_spawn_x;
    logic [8:0]      w_esc_sum;

    assign w_accept  = bus.spawn && (r_holdoff == '0) && (w_active != 8'hFF);
    assign w_spawn_x = 10'(bus.random_number * X_STEP);
    assign w_esc_sum = {1'b0, r_escaped} + {5'd0, f_popcount(w_escape)};

    // Scan downward so the lowest free index is the last one written.
    always_comb begin
        w_free_idx = '0;
        for (int i = c_NSLOT - 1; i >= 0; i--) begin
            if (!w_active[i]) begin
                w_free_idx = 3'(i);
            end
        end
    end

    for (genvar gi = 0; gi < c_NSLOT; gi++) begin : g_slot
        logic        r_act;
        logic [9:0]  r_x;
        logic [9:0]  r_y;
        logic        w_spawn_here;
        logic        w_kill_here;
        logic        w_move;
        logic [10:0] w_y_step;
`ifdef ENEMY_ZIGZAG_EN
        logic        r_dir;
`endif

        // A spawn target is always free, so kill can only hit an already-active slot.
        assign w_spawn_here = w_accept && (w_free_idx == 3'(gi));
        assign w_kill_here  = bus.kill && (bus.kill_slot == 3'(gi)) && r_act;
        assign w_move       = bus.move_tick && r_act && !w_kill_here;
        assign w_y_step     = {1'b0, r_y} + 11'(SPEED);
        assign w_escape[gi] = w_move && (w_y_step >= 11'(SCREEN_H));

        assign w_active[gi]           = r_act;
        assign w_pos_x[10*gi +: 10]   = r_x;
        assign w_pos_y[10*gi +: 10]   = r_y;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_act <= 1'b0;
                r_x   <= '0;
                r_y   <= '0;
`ifdef ENEMY_ZIGZAG_EN
                r_dir <= 1'b0;
`endif
            end else if (w_spawn_here) begin
                r_act <= 1'b1;
                r_x   <= w_spawn_x;
                r_y   <= '0;
`ifdef ENEMY_ZIGZAG_EN
                r_dir <= bus.random_number[0];
`endif
            end else if (w_kill_here) begin
                r_act <= 1'b0;
            end else if (w_move) begin
                r_y <= w_y_step[9:0];
                if (w_escape[gi]) begin
                    r_act <= 1'b0;
                end
`ifdef ENEMY_ZIGZAG_EN
                // Reaching an edge costs one tick: flip only, no X step.
                if (r_dir) begin
                    if (r_x >= 10'(SCREEN_W - ENEMY_W)) begin
                        r_dir <= 1'b0;
                    end else begin
                        r_x <= r_x + 10'(DRIFT);
                    end
                end else begin
                    if (r_x < 10'(DRIFT)) begin
                        r_dir <= 1'b1;
                    end else begin
                        r_x <= r_x - 10'(DRIFT);
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdoff <= '0;
            r_count   <= '0;
            r_escaped <= '0;
            r_spawned <= 1'b0;
        end else begin
            if (w_accept) begin
                r_holdoff <= c_HW'(HOLDOFF - 1);
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - 1'b1;
            end
            r_count   <= f_popcount(w_active);
            r_escaped <= (w_esc_sum > 9'd255) ? 8'hFF : w_esc_sum[7:0];
            r_spawned <= w_accept;
        end
    end

    assign bus.enemy_count   = r_count;
    assign bus.active_mask   = w_active;
    assign bus.pos_x         = w_pos_x;
    assign bus.pos_y         = w_pos_y;
    assign bus.escaped       = r_escaped;
    assign bus.spawned_pulse = r_spawned;

endmodule
`default_nettype wire

// File: tb/tb_enemy_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_pool
// Description : Self-checking bench for enemy_pool; expected spawns are queued
//               and matched against spawned_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_pool;

    logic clk;
    logic rst_n;
    enemy_pool_if bus ();

    enemy_pool u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int slot;
        int x;
    } exp_t;

    exp_t sb[$];
    exp_t r_e;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.spawned_pulse && n < bound);
        if (!bus.spawned_pulse) chk("pulse_timeout", 0, 1);
    endtask

    task automatic move_n(input int n);
        for (int t = 0; t < n; t++) begin
            bus.move_tick = 1'b1;
            tick();
            bus.move_tick = 1'b0;
            tick();
        end
    endtask

    // Scoreboard side: every spawned_pulse must match the oldest queued spawn.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count_le8", 32'(bus.enemy_count <= 4'd8), 1);
            if (bus.spawned_pulse) begin
                if (sb.size() == 0) begin
                    chk("unexpected_spawn", 1, 0);
                end else begin
                    r_e = sb.pop_front();
                    chk("sb_active", 32'(bus.active_mask[r_e.slot]), 1);
                    chk("sb_x", 32'(bus.pos_x[10*r_e.slot +: 10]), r_e.x);
                    chk("sb_y", 32'(bus.pos_y[10*r_e.slot +: 10]), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        rst_n             = 1'b0;
        bus.spawn         = 1'b0;
        bus.random_number = 4'd0;
        bus.move_tick     = 1'b0;
        bus.kill          = 1'b0;
        bus.kill_slot     = 3'd0;
        tick();
        tick();
        chk("rst_mask", 32'(bus.active_mask), 0);
        chk("rst_count", 32'(bus.enemy_count), 0);
        chk("rst_escaped", 32'(bus.escaped), 0);
        chk("rst_pulse", 32'(bus.spawned_pulse), 0);
        chk("rst_posx", 32'(bus.pos_x[31:0]), 0);
        rst_n = 1'b1;

        // First spawn, count latency and holdoff spacing
        bus.spawn         = 1'b1;
        bus.random_number = 4'd5;
        sb.push_back('{0, 180});
        tick();
        chk("spawn0_mask", 32'(bus.active_mask), 1);
        chk("spawn0_pulse", 32'(bus.spawned_pulse), 1);
        chk("count_lat1", 32'(bus.enemy_count), 0);
        tick();
        chk("count_lat2", 32'(bus.enemy_count), 1);
        chk("pulse_oneshot", 32'(bus.spawned_pulse), 0);
        sb.push_back('{1, 180});
        wait_pulse(1100, n);
        chk("holdoff_gap", n + 1, 1000);
        chk("spawn1_mask", 32'(bus.active_mask), 3);

        // Fill the pool
        for (int s = 2; s < 8; s++) begin
            bus.random_number = 4'(s);
            sb.push_back('{s, s * 36});
            wait_pulse(1100, n);
        end
        chk("full_mask", 32'(bus.active_mask), 8'hFF);
        tick();
        chk("full_count", 32'(bus.enemy_count), 8);
        cnt = 0;
        for (int t = 0; t < 1100; t++) begin
            tick();
            if (bus.spawned_pulse) cnt++;
        end
        chk("full_nopulse", cnt, 0);
        bus.spawn = 1'b0;

        // Free slots 4..7, then kill slot 3 while spawning
        for (int s = 4; s < 8; s++) begin
            bus.kill      = 1'b1;
            bus.kill_slot = 3'(s);
            tick();
        end
        bus.kill = 1'b0;
        chk("kill_mask", 32'(bus.active_mask), 8'h0F);
        tick();
        chk("kill_count", 32'(bus.enemy_count), 4);
        bus.kill          = 1'b1;
        bus.kill_slot     = 3'd3;
        bus.spawn         = 1'b1;
        bus.random_number = 4'd9;
        sb.push_back('{4, 324});
        tick();
        bus.kill  = 1'b0;
        bus.spawn = 1'b0;
        chk("killspawn_mask", 32'(bus.active_mask), 8'h17);
        chk("killed_posx_kept", 32'(bus.pos_x[39:30]), 108);
        tick();
        chk("killspawn_count_a", 32'(bus.enemy_count), 4);
        tick();
        chk("killspawn_count_b", 32'(bus.enemy_count), 4);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        chk("midrst_mask", 32'(bus.active_mask), 0);
        chk("midrst_posx", 32'(bus.pos_x[31:0]), 0);
        tick();
        rst_n             = 1'b1;
        bus.spawn         = 1'b1;
        bus.random_number = 4'd0;
        sb.push_back('{0, 0});
        tick();
        bus.spawn = 1'b0;
        chk("postrst_spawn", 32'(bus.spawned_pulse), 1);

        // Escape after 240 ticks
        move_n(239);
        chk("esc_y478", 32'(bus.pos_y[9:0]), 478);
        chk("esc_active", 32'(bus.active_mask), 1);
        chk("esc_before", 32'(bus.escaped), 0);
        move_n(1);
        chk("esc_mask", 32'(bus.active_mask), 0);
        chk("esc_count_esc", 32'(bus.escaped), 1);
        chk("esc_enemy_count", 32'(bus.enemy_count), 0);

        // Spawn together with move_tick, then kill on the escape tick
        bus.spawn         = 1'b1;
        bus.move_tick     = 1'b1;
        bus.random_number = 4'd2;
        sb.push_back('{0, 72});
        wait_pulse(1100, n);
        bus.spawn     = 1'b0;
        bus.move_tick = 1'b0;
        move_n(239);
        chk("kmv_y478", 32'(bus.pos_y[9:0]), 478);
        bus.kill      = 1'b1;
        bus.kill_slot = 3'd0;
        bus.move_tick = 1'b1;
        tick();
        bus.kill      = 1'b0;
        bus.move_tick = 1'b0;
        chk("kmv_mask", 32'(bus.active_mask), 0);
        chk("kmv_escaped", 32'(bus.escaped), 1);
        chk("kmv_y_kept", 32'(bus.pos_y[9:0]), 478);

`ifdef ENEMY_ZIGZAG_EN
        bus.spawn         = 1'b1;
        bus.random_number = 4'd15;
        sb.push_back('{0, 540});
        wait_pulse(1100, n);
        bus.spawn = 1'b0;
        move_n(68);
        chk("zz_x608", 32'(bus.pos_x[9:0]), 608);
        move_n(1);
        chk("zz_flip", 32'(bus.pos_x[9:0]), 608);
        move_n(1);
        chk("zz_x607", 32'(bus.pos_x[9:0]), 607);
`endif

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
